atm_ledger_arbiter: RTL
=======================

Name: atm_ledger_arbiter

Overview:
- Shared account-balance ledger plus the controller that serialises access to it from several ATM front-end channels.
- Round-robin arbitration between requesters; each granted transaction is one atomic read-check-write over an internal balance register file.
- Supported transactions: balance query, deposit, withdraw, transfer.
- Sits between the ATM session FSMs (requesters) and the account storage.

Parameters:
- N_REQ, 4, number of requesting ATM channels.
- ACCT_W, 4, account index width (2**ACCT_W accounts).
- AMT_W, 19, transaction amount width.
- BAL_W, 20, balance width; must be greater than AMT_W.
- INIT_BAL, 1000, balance of every account after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-channel request; held high until done.
- req_op  in  2*N_REQ  per-channel opcode: 0 BAL, 1 DEP, 2 WDR, 3 XFER.
- req_acct  in  ACCT_W*N_REQ  per-channel source account.
- req_dst  in  ACCT_W*N_REQ  per-channel destination account (XFER only).
- req_amt  in  AMT_W*N_REQ  per-channel amount.
- gnt  out  N_REQ  one-hot; the active winner.
- done  out  N_REQ  one-cycle completion pulse to the winner.
- status  out  2  0 OK, 1 INSUFF, 2 OVERFLOW, 3 BAD_ACCT; valid while done is high.
- rsp_balance  out  BAL_W  post-operation source balance; valid while done is high.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - gnt=0, done=0, status=0, rsp_balance=0, busy=0.
  - FSM goes to IDLE; RR pointer set so channel 0 has top priority.
  - Every balance set to INIT_BAL.
- FSM states: IDLE, LOAD, EXEC, RESP.
  - IDLE: at an edge with req!=0, register one-hot gnt for the RR winner, latch its op, accounts and amount; go to LOAD. If req==0, stay in IDLE.
  - LOAD: register src_bal=bal[acct] and dst_bal=bal[dst]; go to EXEC.
  - EXEC: compute the result, perform all balance writes in this single edge, register status and rsp_balance, set done[winner]=1; go to RESP.
  - RESP: done is high for this one cycle. At the next edge, clear done and gnt, advance the RR pointer to the winner, go to IDLE.
- Latency and throughput:
  - done is high in the 3rd cycle after the granting edge.
  - Minimum spacing between grants is 4 cycles.
- Round robin: search order starts at last_winner+1 and wraps modulo N_REQ.
- Requester handshake:
  - Operands must stay stable from req rise until done.
  - req must drop within one cycle after done.
  - If req drops early, the transaction still completes and done still pulses; no abort.
- Arithmetic (amounts zero-extended to BAL_W+1 for the compare):
  - BAL: no write; status OK; rsp = bal.
  - DEP: if bal+amt > 2**BAL_W-1, status OVERFLOW and no write; else write the sum.
  - WDR: if amt > bal, status INSUFF and no write; else write bal-amt. amt==bal is OK and leaves 0.
  - XFER: check in priority order: acct==dst gives BAD_ACCT; amt>src gives INSUFF; dst+amt overflow gives OVERFLOW. Otherwise write both accounts in the same edge.
  - Any error: no account changes; rsp = unchanged source balance.
  - amt==0 is legal; status OK; balances unchanged.
- Reset mid-transaction: no partial update is possible because writes happen only at the EXEC edge. Outputs clear immediately.

Decomposition:
- Package atm_ledger_pkg holds:
  - op enum (BAL/DEP/WDR/XFER);
  - status enum (OK/INSUFF/OVERFLOW/BAD_ACCT);
  - state enum.
- Sub-module rr_arbiter (parameter N): inputs req and last-winner pointer; output one-hot grant. Purely combinational.
- Ledger register file and FSM live in the top module.

Test Plan:
- Reset, then req0 BAL acct 3 -> gnt[0]; done[0] three cycles later; status OK; rsp 1000; all outputs 0 during reset.
- req0 WDR acct 2 amt 300 -> OK, rsp 700. Then WDR acct 2 amt 800 -> INSUFF, rsp 700. Then BAL acct 2 -> 700.
- XFER acct 1->5 amt 250 -> OK, rsp 750; BAL acct 5 -> 1250. XFER 4->4 amt 10 -> BAD_ACCT, rsp 1000.
- req[3:0]=1111 BAL, each dropping after its done -> grants in order 0,1,2,3 spaced 4 cycles apart. Then req1 and req3 together -> req1 granted first.
- DEP acct 0 amt 524287 -> OK, rsp 525287. Repeat -> OVERFLOW, rsp 525287.
- WDR acct 6 amt 500; assert reset during EXEC -> gnt/done drop at once; BAL acct 6 after release -> 1000.

Source files
------------

// File: rtl/atm_ledger_pkg.sv
// Shared types for the ATM ledger arbiter: opcodes, completion status and FSM states.
package atm_ledger_pkg;

    typedef enum logic [1:0] {
        OP_BAL  = 2'd0,
        OP_DEP  = 2'd1,
        OP_WDR  = 2'd2,
        OP_XFER = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_INSUFF   = 2'd1,
        ST_OVERFLOW = 2'd2,
        ST_BAD_ACCT = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EXEC = 2'd2,
        S_RESP = 2'd3
    } state_e;

endpackage

// File: rtl/atm_ledger_if.sv
// Request/response bundle between the ATM session channels (master) and the ledger (slave).
interface atm_ledger_if #(
    parameter int N_REQ  = 4,
    parameter int ACCT_W = 4,
    parameter int AMT_W  = 19,
    parameter int BAL_W  = 20
);
    logic [N_REQ-1:0]        req;
    logic [2*N_REQ-1:0]      req_op;
    logic [ACCT_W*N_REQ-1:0] req_acct;
    logic [ACCT_W*N_REQ-1:0] req_dst;
    logic [AMT_W*N_REQ-1:0]  req_amt;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        done;
    logic [1:0]              status;
    logic [BAL_W-1:0]        rsp_balance;
    logic                    busy;

    modport master (
        output req, req_op, req_acct, req_dst, req_amt,
        input  gnt, done, status, rsp_balance, busy
    );

    modport slave (
        input  req, req_op, req_acct, req_dst, req_amt,
        output gnt, done, status, rsp_balance, busy
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last winner and wraps.
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] last,
    output logic [N-1:0]  gnt
);
    int   idx;
    logic found;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last) + i) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/atm_ledger_arbiter.sv
// Shared balance ledger with a round-robin controller; each grant runs one atomic
// read-check-write transaction over the internal balance register file.
module atm_ledger_arbiter
    import atm_ledger_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int ACCT_W   = 4,
    parameter int AMT_W    = 19,
    parameter int BAL_W    = 20,
    parameter int INIT_BAL = 1000
) (
    input logic          clk,
    input logic          reset,
    atm_ledger_if.slave  bus
);
    localparam int PW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int N_ACCT = 2 ** ACCT_W;

    state_e              state_q;
    logic [N_REQ-1:0]    gnt_q, done_q;
    status_e             status_q;
    logic [BAL_W-1:0]    rsp_q;
    logic [PW-1:0]       last_q, win_q;
    op_e                 op_q;
    logic [ACCT_W-1:0]   acct_q, dst_q;
    logic [AMT_W-1:0]    amt_q;
    logic [BAL_W-1:0]    src_bal_q, dst_bal_q;
    logic [BAL_W-1:0]    bal_q [N_ACCT];

    logic [N_REQ-1:0]    arb_gnt;
    logic [PW-1:0]       win_d;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req  (bus.req),
        .last (last_q),
        .gnt  (arb_gnt)
    );

    always_comb begin
        win_d = '0;
        for (int i = 0; i < N_REQ; i++)
            if (arb_gnt[i]) win_d = PW'(i);
    end

    // Result of the EXEC step; one extra bit catches sums past the balance range.
    logic [BAL_W:0]   amt_ext, src_ext, src_sum, dst_sum;
    status_e          status_d;
    logic [BAL_W-1:0] new_src_d, new_dst_d;
    logic             wr_src_d, wr_dst_d;

    always_comb begin
        amt_ext   = {{(BAL_W + 1 - AMT_W){1'b0}}, amt_q};
        src_ext   = {1'b0, src_bal_q};
        src_sum   = src_ext + amt_ext;
        dst_sum   = {1'b0, dst_bal_q} + amt_ext;
        status_d  = ST_OK;
        new_src_d = src_bal_q;
        new_dst_d = dst_bal_q;
        wr_src_d  = 1'b0;
        wr_dst_d  = 1'b0;
        case (op_q)
            OP_BAL: ;
            OP_DEP:
                if (src_sum[BAL_W]) status_d = ST_OVERFLOW;
                else begin
                    wr_src_d  = 1'b1;
                    new_src_d = src_sum[BAL_W-1:0];
                end
            OP_WDR:
                if (amt_ext > src_ext) status_d = ST_INSUFF;
                else begin
                    wr_src_d  = 1'b1;
                    new_src_d = src_bal_q - amt_ext[BAL_W-1:0];
                end
            OP_XFER:
                if (acct_q == dst_q)       status_d = ST_BAD_ACCT;
                else if (amt_ext > src_ext) status_d = ST_INSUFF;
                else if (dst_sum[BAL_W])    status_d = ST_OVERFLOW;
                else begin
                    wr_src_d  = 1'b1;
                    wr_dst_d  = 1'b1;
                    new_src_d = src_bal_q - amt_ext[BAL_W-1:0];
                    new_dst_d = dst_sum[BAL_W-1:0];
                end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            status_q  <= ST_OK;
            rsp_q     <= '0;
            last_q    <= PW'(N_REQ - 1);
            win_q     <= '0;
            op_q      <= OP_BAL;
            acct_q    <= '0;
            dst_q     <= '0;
            amt_q     <= '0;
            src_bal_q <= '0;
            dst_bal_q <= '0;
            // NOTE: the balance file is architectural state, so it is reset like any other register.
            for (int a = 0; a < N_ACCT; a++) bal_q[a] <= BAL_W'(INIT_BAL);
        end else begin
            case (state_q)
                S_IDLE:
                    if (|bus.req) begin
                        gnt_q   <= arb_gnt;
                        win_q   <= win_d;
                        op_q    <= op_e'(bus.req_op[2*int'(win_d) +: 2]);
                        acct_q  <= bus.req_acct[ACCT_W*int'(win_d) +: ACCT_W];
                        dst_q   <= bus.req_dst[ACCT_W*int'(win_d) +: ACCT_W];
                        amt_q   <= bus.req_amt[AMT_W*int'(win_d) +: AMT_W];
                        state_q <= S_LOAD;
                    end
                S_LOAD: begin
                    src_bal_q <= bal_q[acct_q];
                    dst_bal_q <= bal_q[dst_q];
                    state_q   <= S_EXEC;
                end
                S_EXEC: begin
                    if (wr_src_d) bal_q[acct_q] <= new_src_d;
                    if (wr_dst_d) bal_q[dst_q]  <= new_dst_d;
                    status_q <= status_d;
                    rsp_q    <= new_src_d;
                    done_q   <= gnt_q;
                    state_q  <= S_RESP;
                end
                S_RESP: begin
                    done_q  <= '0;
                    gnt_q   <= '0;
                    last_q  <= win_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.done        = done_q;
    assign bus.status      = status_q;
    assign bus.rsp_balance = rsp_q;
    assign bus.busy        = (state_q != S_IDLE);
endmodule
